// File: rtl/laser_host.sv
// Host-side feeder/checker for the LASER circle-placement engine: loads point
// patterns, streams them to the engine, captures the centres and scores coverage.
module laser_host #(
  parameter int NPTS        = 40,
  parameter int NUM_PAT_MAX = 4,
  parameter int ADDR_W      = 8,
  parameter int TO_W        = 16,
  parameter int MAX_WAIT    = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LD_EN,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [3:0]        LD_X,
  input  logic [3:0]        LD_Y,
  input  logic              START,
  input  logic [1:0]        NUM_PAT,
  output logic              BUSY,
  output logic              LASER_RST,
  output logic [3:0]        X,
  output logic [3:0]        Y,
  input  logic [3:0]        C1X,
  input  logic [3:0]        C1Y,
  input  logic [3:0]        C2X,
  input  logic [3:0]        C2Y,
  input  logic              DONE,
  output logic              RES_VALID,
  output logic [1:0]        RES_PAT,
  output logic [3:0]        RES_C1X,
  output logic [3:0]        RES_C1Y,
  output logic [3:0]        RES_C2X,
  output logic [3:0]        RES_C2Y,
  output logic [5:0]        RES_COV,
  output logic              ERR
);

  localparam int DEPTH = NPTS * NUM_PAT_MAX;
  localparam int IDX_W = $clog2(NPTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [3:0] c1x;
    logic [3:0] c1y;
    logic [3:0] c2x;
    logic [3:0] c2y;
  } centres_t;

  // ---------------------------------------------------------------------------
  // Point memory
  // ---------------------------------------------------------------------------
  logic [3:0] mem_x [DEPTH];
  logic [3:0] mem_y [DEPTH];
  logic       mem_we;

  // NOTE: the point memory has no reset on purpose; patterns survive RST and
  // a reset network on every entry would only cost area.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_x[LD_ADDR] <= LD_X;
      mem_y[LD_ADDR] <= LD_Y;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            state_q,   state_d;
  logic [1:0]        pat_q,     pat_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [1:0]        num_pat_q, num_pat_d;
  logic [TO_W-1:0]   to_cnt_q,  to_cnt_d;
  logic              err_q,     err_d;
  logic              capture;

  logic              sc_active_q, sc_active_d;
  logic [IDX_W-1:0]  sc_idx_q,    sc_idx_d;
  logic [1:0]        sc_pat_q,    sc_pat_d;
  centres_t          sc_cen_q,    sc_cen_d;
  logic [5:0]        sc_cnt_q,    sc_cnt_d;

  logic              res_valid_q, res_valid_d;
  logic [1:0]        res_pat_q,   res_pat_d;
  centres_t          res_cen_q,   res_cen_d;
  logic [5:0]        res_cov_q,   res_cov_d;

  assign mem_we = LD_EN && (state_q == S_IDLE) &&
                  ({1'b0, LD_ADDR} < (ADDR_W+1)'(DEPTH));

  // Two independent read paths: the stream port and the scorer.
  logic [ADDR_W-1:0] st_addr;
  logic [ADDR_W-1:0] sc_addr;
  assign st_addr = ADDR_W'(pat_q) * ADDR_W'(NPTS) + ADDR_W'(idx_q);
  assign sc_addr = ADDR_W'(sc_pat_q) * ADDR_W'(NPTS) + ADDR_W'(sc_idx_q);

  // ---------------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written below gets a default first so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    num_pat_d = num_pat_q;
    to_cnt_d  = '0;
    err_d     = err_q;
    capture   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_STREAM;
          num_pat_d = NUM_PAT;
          pat_d     = '0;
          idx_d     = '0;
          err_d     = 1'b0;
        end
      end
      S_STREAM: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NPTS - 1)) begin
          state_d = S_WAIT;
          idx_d   = '0;
        end
      end
      S_WAIT: begin
        if (DONE) begin
          capture = 1'b1;
          if (pat_q == num_pat_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_STREAM;
            pat_d   = pat_q + 1'b1;
            idx_d   = '0;
          end
        end else if (to_cnt_q == TO_W'(MAX_WAIT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY      = (state_q != S_IDLE);
  assign LASER_RST = (state_q == S_IDLE);
  assign X         = (state_q == S_STREAM) ? mem_x[st_addr] : 4'd0;
  assign Y         = (state_q == S_STREAM) ? mem_y[st_addr] : 4'd0;
  assign ERR       = err_q;

  // ---------------------------------------------------------------------------
  // Scorer
  // ---------------------------------------------------------------------------
  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] dx2;
    logic [7:0] dy2;
    logic [8:0] sum;
    dx  = (px >= cx) ? px - cx : cx - px;
    dy  = (py >= cy) ? py - cy : cy - py;
    dx2 = {4'd0, dx} * {4'd0, dx};
    dy2 = {4'd0, dy} * {4'd0, dy};
    sum = {1'b0, dx2} + {1'b0, dy2};
    return sum <= 9'd16;
  endfunction

  logic pt_cov;
  assign pt_cov = in_circle(mem_x[sc_addr], mem_y[sc_addr], sc_cen_q.c1x, sc_cen_q.c1y) |
                  in_circle(mem_x[sc_addr], mem_y[sc_addr], sc_cen_q.c2x, sc_cen_q.c2y);

  always_comb begin
    sc_active_d = sc_active_q;
    sc_idx_d    = sc_idx_q;
    sc_pat_d    = sc_pat_q;
    sc_cen_d    = sc_cen_q;
    sc_cnt_d    = sc_cnt_q;
    res_valid_d = 1'b0;
    res_pat_d   = res_pat_q;
    res_cen_d   = res_cen_q;
    res_cov_d   = res_cov_q;

    if (sc_active_q) begin
      sc_cnt_d = sc_cnt_q + {5'd0, pt_cov};
      sc_idx_d = sc_idx_q + 1'b1;
      if (sc_idx_q == IDX_W'(NPTS - 1)) begin
        sc_active_d = 1'b0;
        res_valid_d = 1'b1;
        res_pat_d   = sc_pat_q;
        res_cen_d   = sc_cen_q;
        res_cov_d   = sc_cnt_d;
      end
    end

    // A fresh capture cannot overlap a running score; it simply restarts it.
    if (capture) begin
      sc_active_d = 1'b1;
      sc_idx_d    = '0;
      sc_cnt_d    = '0;
      sc_pat_d    = pat_q;
      sc_cen_d    = '{c1x: C1X, c1y: C1Y, c2x: C2X, c2y: C2Y};
    end
  end

  assign RES_VALID = res_valid_q;
  assign RES_PAT   = res_pat_q;
  assign RES_C1X   = res_cen_q.c1x;
  assign RES_C1Y   = res_cen_q.c1y;
  assign RES_C2X   = res_cen_q.c2x;
  assign RES_C2Y   = res_cen_q.c2y;
  assign RES_COV   = res_cov_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every register samples the values
  // of the previous cycle regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      idx_q       <= '0;
      num_pat_q   <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      sc_active_q <= 1'b0;
      sc_idx_q    <= '0;
      sc_pat_q    <= '0;
      sc_cen_q    <= '0;
      sc_cnt_q    <= '0;
      res_valid_q <= 1'b0;
      res_pat_q   <= '0;
      res_cen_q   <= '0;
      res_cov_q   <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      idx_q       <= idx_d;
      num_pat_q   <= num_pat_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      sc_active_q <= sc_active_d;
      sc_idx_q    <= sc_idx_d;
      sc_pat_q    <= sc_pat_d;
      sc_cen_q    <= sc_cen_d;
      sc_cnt_q    <= sc_cnt_d;
      res_valid_q <= res_valid_d;
      res_pat_q   <= res_pat_d;
      res_cen_q   <= res_cen_d;
      res_cov_q   <= res_cov_d;
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// Self-checking bench for laser_host: directed scenarios plus random patterns,
// scored against a plain-arithmetic coverage model.
module tb_laser_host;

  localparam int NPTS = 40;
  localparam int MW   = 200;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LD_EN = 1'b0;
  logic [7:0] LD_ADDR = '0;
  logic [3:0] LD_X = '0, LD_Y = '0;
  logic       START = 1'b0;
  logic [1:0] NUM_PAT = '0;
  logic       BUSY, LASER_RST;
  logic [3:0] X, Y;
  logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic       DONE = 1'b0;
  logic       RES_VALID;
  logic [1:0] RES_PAT;
  logic [3:0] RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
  logic [5:0] RES_COV;
  logic       ERR;

  laser_host #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST),
    .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_X(LD_X), .LD_Y(LD_Y),
    .START(START), .NUM_PAT(NUM_PAT), .BUSY(BUSY), .LASER_RST(LASER_RST),
    .X(X), .Y(Y), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
    .RES_VALID(RES_VALID), .RES_PAT(RES_PAT),
    .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y), .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y),
    .RES_COV(RES_COV), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int rv_cnt = 0;
  int px [4][NPTS];
  int py [4][NPTS];
  int cen [4][4];
  int dly [4];

  always @(posedge CLK) if (RES_VALID === 1'b1) rv_cnt++;

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int p, input int i, input int x, input int y);
    LD_EN = 1'b1; LD_ADDR = 8'(p * NPTS + i); LD_X = 4'(x); LD_Y = 4'(y);
    px[p][i] = x; py[p][i] = y;
    step();
    LD_EN = 1'b0;
  endtask

  function automatic int ref_cov(input int p);
    int n = 0;
    for (int i = 0; i < NPTS; i++) begin
      int d1 = (px[p][i] - cen[p][0]) ** 2 + (py[p][i] - cen[p][1]) ** 2;
      int d2 = (px[p][i] - cen[p][2]) ** 2 + (py[p][i] - cen[p][3]) ** 2;
      if (d1 <= 16 || d2 <= 16) n++;
    end
    return n;
  endfunction

  task automatic check_result(input int p, input int expv);
    check("res_valid", RES_VALID, 1);
    check("res_pat",   RES_PAT, p);
    check("res_cov",   RES_COV, expv);
    check("res_c1",    {RES_C1X, RES_C1Y}, {4'(cen[p][0]), 4'(cen[p][1])});
    check("res_c2",    {RES_C2X, RES_C2Y}, {4'(cen[p][2]), 4'(cen[p][3])});
  endtask

  task automatic random_centres(input int np);
    for (int p = 0; p <= np; p++) begin
      int r = $urandom_range(0, NPTS - 1);
      cen[p][0] = px[p][r];
      cen[p][1] = py[p][r];
      cen[p][2] = $urandom_range(0, 15);
      cen[p][3] = $urandom_range(0, 15);
      dly[p]    = $urandom_range(1, 120);
    end
  endtask

  // Full run with the engine stub inline; abort_at>0 resets during scoring.
  task automatic run(input int np, input int abort_at);
    int expv [4];
    int rv0 = rv_cnt;
    for (int p = 0; p <= np; p++) expv[p] = ref_cov(p);
    START = 1'b1; NUM_PAT = 2'(np);
    step();
    START = 1'b0;
    check("busy_rise", BUSY, 1);
    check("lrst_fall", LASER_RST, 0);
    check("err_clear", ERR, 0);
    for (int p = 0; p <= np; p++) begin
      for (int i = 0; i < NPTS; i++) begin
        check("stream_xy", {X, Y}, {4'(px[p][i]), 4'(py[p][i])});
        check("stream_lrst", LASER_RST, 0);
        step();
      end
      check("wait_xy", {X, Y}, 8'd0);
      if (p > 0) check_result(p - 1, expv[p - 1]);
      if (dly[p] > 1) step(dly[p] - 1);
      DONE = 1'b1;
      C1X = 4'(cen[p][0]); C1Y = 4'(cen[p][1]);
      C2X = 4'(cen[p][2]); C2Y = 4'(cen[p][3]);
      step();
      DONE = 1'b0;
    end
    check("busy_fall", BUSY, 0);
    check("lrst_idle", LASER_RST, 1);
    if (abort_at > 0) begin
      step(abort_at);
      RST = 1'b1;
      step();
      RST = 1'b0;
      check("abort_busy", BUSY, 0);
      check("abort_cov", RES_COV, 0);
      step(45);
      check("abort_no_rv", rv_cnt - rv0, 0);
    end else begin
      step(39);
      check("rv_early", RES_VALID, 0);
      step();
      check_result(np, expv[np]);
      step();
      check("rv_pulse", RES_VALID, 0);
      check("rv_count", rv_cnt - rv0, np + 1);
    end
  endtask

  initial begin
    int rv0;

    // Reset state, and DONE while idle is ignored
    step(3);
    RST = 1'b0;
    check("rst_busy", BUSY, 0);
    check("rst_lrst", LASER_RST, 1);
    check("rst_xy", {X, Y}, 8'd0);
    check("rst_res", {RES_VALID, RES_PAT, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, RES_COV}, 0);
    check("rst_err", ERR, 0);
    DONE = 1'b1; step(); DONE = 1'b0;
    step(45);
    check("idle_done_ignored", rv_cnt, 0);
    check("idle_busy", BUSY, 0);

    // 1: all points at (8,8), centres on top of them
    for (int i = 0; i < NPTS; i++) load(0, i, 8, 8);
    cen[0] = '{8, 8, 8, 8};
    dly[0] = 100;
    run(0, 0);
    check("all_covered", RES_COV, 40);

    // 2: distinct stream ordering
    for (int i = 0; i < NPTS; i++) load(0, i, i % 16, i / 16);
    random_centres(0);
    run(0, 0);

    // 3: inclusion boundary
    for (int i = 0; i < NPTS; i++) load(0, i, 15, 15);
    load(0, 0, 8, 12);
    load(0, 1, 11, 10);
    load(0, 2, 11, 11);
    load(0, 3, 2, 2);
    cen[0] = '{8, 8, 0, 0};
    dly[0] = 1;
    run(0, 0);
    check("boundary_cov", RES_COV, 3);

    // 4: four random patterns back to back
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 4; p++)
        for (int i = 0; i < NPTS; i++)
          load(p, i, $urandom_range(0, 15), $urandom_range(0, 15));
      random_centres(3);
      run(3, 0);
    end

    // 5: timeout
    rv0 = rv_cnt;
    START = 1'b1; NUM_PAT = 2'd0;
    step();
    START = 1'b0;
    step(NPTS);
    check("to_wait_xy", {X, Y}, 8'd0);
    step(MW - 1);
    check("to_last_wait", {BUSY, ERR}, 2'b10);
    step();
    check("to_idle", {BUSY, ERR, LASER_RST}, 3'b011);
    step(50);
    check("to_err_sticky", ERR, 1);
    check("to_no_rv", rv_cnt - rv0, 0);
    random_centres(0);
    run(0, 0);

    // 6: RST mid-stream with ignored writes, then mid-scoring, then rerun
    START = 1'b1; NUM_PAT = 2'd0;
    step();
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      LD_EN = 1'b1; LD_ADDR = 8'(i); LD_X = 4'(~px[0][i]); LD_Y = 4'(~py[0][i]);
      step();
    end
    LD_EN = 1'b0;
    check("mid_busy", BUSY, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_stream", {BUSY, LASER_RST, X, Y}, {1'b0, 1'b1, 8'd0});
    random_centres(0);
    run(0, 20);
    random_centres(0);
    run(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/laser_host.md
Name: laser_host

Overview:
- Host-side driver for the LASER circle-placement engine; the other end of its point-stream/result interface.
- Holds up to NUM_PAT_MAX patterns of 40 (X,Y) points loaded through a write port, owns the engine's reset, and streams one point per cycle.
- Waits for DONE, captures the two circle centres, then independently scores them: counts the points covered by either radius-4 circle.
- Used as the system-level feeder/checker in front of LASER.

Parameters:
- NPTS, 40, points per pattern.
- NUM_PAT_MAX, 4, pattern slots in point memory.
- ADDR_W, 8, load address width; must satisfy 2^ADDR_W >= NPTS*NUM_PAT_MAX.
- TO_W, 16, timeout counter width.
- MAX_WAIT, 65535, cycles allowed in WAIT_DONE before a timeout.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- LD_EN  in  1  point-memory write strobe
- LD_ADDR  in  ADDR_W  entry address = pattern*NPTS + index
- LD_X, LD_Y  in  4 each  point coordinates
- START  in  1  one-cycle run request
- NUM_PAT  in  2  number of patterns to run, minus 1; sampled on START
- BUSY  out  1  run in progress
- LASER_RST  out  1  reset to the engine
- X, Y  out  4 each  point stream to the engine
- C1X, C1Y, C2X, C2Y  in  4 each  centres from the engine
- DONE  in  1  engine result strobe
- RES_VALID  out  1  one-cycle result strobe
- RES_PAT  out  2  pattern index of the result
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured centres
- RES_COV  out  6  covered-point count, 0..40
- ERR  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; BUSY=0, LASER_RST=1, X=Y=0, all RES_* outputs=0, ERR=0, scorer idle. Point memory is not cleared by RST.
- Memory writes: allowed only when BUSY=0. LD_EN while busy is ignored. Writes take effect on the next edge.
- Main FSM, state IDLE:
  - LASER_RST=1, X=Y=0.
  - START moves to STREAM: latch NUM_PAT, pat=0, idx=0, clear ERR, BUSY=1 from the next cycle.
  - START while BUSY=1 is ignored.
- Main FSM, state STREAM:
  - LASER_RST=0; X/Y = mem[pat*NPTS+idx], decoded from registers only.
  - idx increments each cycle. idx=NPTS-1 moves to WAIT_DONE.
  - Point 0 appears in the first cycle LASER_RST is low; exactly 40 consecutive cycles, no gaps.
- Main FSM, state WAIT_DONE:
  - X=Y=0; timeout counter increments each cycle.
  - On DONE=1:
    - Capture C1X..C2Y and pat into result registers; start the scorer; clear the timeout counter.
    - If pat==NUM_PAT latched: go to IDLE, BUSY=0 next cycle.
    - Otherwise pat+1, idx=0, go to STREAM, so point 0 of the next pattern is driven the cycle after DONE. This matches the engine returning to input immediately.
  - Timeout: counter reaching MAX_WAIT without DONE sets ERR=1 and goes to IDLE, which re-asserts LASER_RST. ERR stays set until the next accepted START or RST.
- DONE outside WAIT_DONE is ignored.
- Scorer:
  - If DONE is captured at cycle t, cycles t+1..t+40 each evaluate one point of the captured pattern.
  - dx=|x−cx|, dy=|y−cy|, unsigned 4-bit magnitudes; squares are 8-bit, sums 9-bit.
  - A point is covered if dx1²+dy1²<=16 OR dx2²+dy2²<=16. The count is a 6-bit accumulator cleared on start.
  - RES_VALID=1 for exactly cycle t+41. RES_* outputs hold their values until the next result.
- Scorer/stream overlap: the scorer reads memory through its own read path, concurrent with streaming of the next pattern. A new DONE cannot arrive within 41 cycles because streaming alone takes 40 cycles plus engine compute, so no scorer collision handling is required.
- A timeout does not cancel a scorer run already in progress.
- RST mid-operation: FSM and scorer abort immediately, no RES_VALID is emitted, LASER_RST=1 from the cycle after RST.

Test Plan:
1. All 40 points at (8,8), NUM_PAT=0; stub asserts DONE 100 cycles after the stream ends with C1=C2=(8,8) -> RES_COV=40, RES_PAT=0, RES_VALID 41 cycles after DONE, BUSY drops the cycle after DONE.
2. Load point i = (i mod 16, i/16); START -> LASER_RST falls the cycle after START; X/Y present points 0..39 on 40 consecutive cycles, then 0.
3. Inclusion boundary, C1=(8,8), C2=(0,0):
   - Points (8,12) and (11,10) are covered.
   - Point (11,11) is not covered (sum 18).
   - Point (2,2) is covered via C2.
   - Remaining 36 points at (15,15).
   - Expected: RES_COV=3.
4. NUM_PAT=3 with distinct patterns -> point 0 of pattern p+1 is driven the cycle after each DONE; four RES_VALID pulses with RES_PAT 0,1,2,3; correct counts; BUSY falls after the 4th DONE.
5. MAX_WAIT=200, stub never asserts DONE -> ERR=1 and BUSY=0 after 200 wait cycles, LASER_RST=1, no RES_VALID; next START clears ERR.
6. RST asserted mid-STREAM and mid-scoring -> BUSY=0, LASER_RST=1, no RES_VALID; LD_EN during BUSY leaves memory unchanged, checked via a rerun.
